// File: rtl/jtframe_joy_pkg.sv
// jtframe_joy_pkg: state encodings and width helpers shared by the joystick chain reader.
package jtframe_joy_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEL   = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    function automatic int chain_len(input int players, input int bits);
        return players * bits;
    endfunction

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/jtframe_joy_tick.sv
// jtframe_joy_tick: free-running CLKDIV divider; tick marks the last clk of each tick period.
module jtframe_joy_tick
    import jtframe_joy_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = cnt_w(CLKDIV);

    logic [W-1:0] div_q, div_d;

    assign tick = div_q == W'(CLKDIV - 1);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end

endmodule

// File: rtl/jtframe_joy_shift.sv
// jtframe_joy_shift: N-player 74165 joystick chain reader with multi-phase SELECT sequencing.
// Phases are gathered in a buffer and published to joy_raw in a single cycle.
module jtframe_joy_shift
    import jtframe_joy_pkg::*;
#(
    parameter int PLAYERS    = 2,
    parameter int BITS       = 8,
    parameter int PHASES     = 2,
    parameter int CLKDIV     = 4,
    parameter int SETTLE     = 2,
    parameter int GAP        = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             JOY_DATA,
    output logic                             JOY_CLK,
    output logic                             JOY_LOAD,
    output logic                             JOY_SELECT,
    output logic [PHASES*PLAYERS*BITS-1:0]   joy_raw,
    output logic                             done,
    output logic                             busy
);
    localparam int LEN = chain_len(PLAYERS, BITS);
    localparam int FW  = PHASES * LEN;
    localparam int CW  = cnt_w(max3(2 * LEN, SETTLE, GAP));
    localparam int PW  = cnt_w(PHASES);

    logic [2:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic          sel_q, sel_d, jclk_q, jclk_d, load_q, load_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [LEN-1:0] sr_q, sr_d;
    logic [FW-1:0] buf_q, buf_d, raw_q, raw_d;
    logic [1:0]    sync_q, sync_d;
    logic          din, tick;

    jtframe_joy_tick #(.CLKDIV(CLKDIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign din = sync_q[1] ^ ACTIVE_LOW;

    always_comb begin
        sync_d = {sync_q[0], JOY_DATA};
        st_d   = st_q;
        cnt_d  = cnt_q;
        ph_d   = ph_q;
        sel_d  = sel_q;
        jclk_d = jclk_q;
        load_d = load_q;
        busy_d = busy_q;
        done_d = 1'b0;
        sr_d   = sr_q;
        buf_d  = buf_q;
        raw_d  = raw_q;
        if (tick) begin
            case (st_q)
                ST_IDLE: if (en) begin
                    st_d   = ST_SEL;
                    ph_d   = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    sel_d  = 1'b1;
                end
                ST_SEL: if (cnt_q == CW'(SETTLE - 1)) begin
                    st_d   = ST_LOAD;
                    cnt_d  = '0;
                    load_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                ST_LOAD: begin
                    st_d   = ST_SHIFT;
                    load_d = 1'b1;
                end
                ST_SHIFT: begin
                    jclk_d = ~jclk_q;
                    cnt_d  = cnt_q + 1'b1;
                    // sample just before the rising edge is driven out
                    if (!jclk_q) sr_d = LEN'({sr_q, din});
                    if (cnt_q == CW'(2 * LEN - 1)) begin
                        jclk_d = 1'b0;
                        cnt_d  = '0;
                        buf_d[int'(ph_q)*LEN +: LEN] = sr_q;
                        if (ph_q == PW'(PHASES - 1)) begin
                            st_d   = ST_GAP;
                            raw_d  = buf_d;
                            done_d = 1'b1;
                            sel_d  = 1'b1;
                        end else begin
                            st_d  = ST_SEL;
                            ph_d  = ph_q + 1'b1;
                            sel_d = ~ph_d[0];
                        end
                    end
                end
                ST_GAP: if (cnt_q == CW'(GAP - 1)) begin
                    st_d   = ST_IDLE;
                    busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            ph_q   <= '0;
            sel_q  <= 1'b1;
            jclk_q <= 1'b0;
            load_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sr_q   <= '0;
            buf_q  <= '0;
            raw_q  <= '0;
            sync_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            sel_q  <= sel_d;
            jclk_q <= jclk_d;
            load_q <= load_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sr_q   <= sr_d;
            buf_q  <= buf_d;
            raw_q  <= raw_d;
            sync_q <= sync_d;
        end
    end

    assign JOY_CLK    = jclk_q;
    assign JOY_LOAD   = load_q;
    assign JOY_SELECT = sel_q;
    assign joy_raw    = raw_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_jtframe_joy_shift.sv
// tb_jtframe_joy_shift: three reader configurations driven by 74165 chain models,
// with a frame scoreboard and a continuous pin-protocol checker.
module tb_jtframe_joy_shift;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [2:0] jclk, jload, jsel, jdone, jbusy, jdata;
    logic [31:0]  raw0, raw1;
    logic [191:0] raw2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    jtframe_joy_shift u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .JOY_DATA(jdata[0]), .JOY_CLK(jclk[0]),
        .JOY_LOAD(jload[0]), .JOY_SELECT(jsel[0]), .joy_raw(raw0), .done(jdone[0]), .busy(jbusy[0])
    );
    jtframe_joy_shift #(.ACTIVE_LOW(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .JOY_DATA(jdata[1]), .JOY_CLK(jclk[1]),
        .JOY_LOAD(jload[1]), .JOY_SELECT(jsel[1]), .joy_raw(raw1), .done(jdone[1]), .busy(jbusy[1])
    );
    jtframe_joy_shift #(.PLAYERS(4), .BITS(12), .PHASES(4), .ACTIVE_LOW(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .JOY_DATA(jdata[2]), .JOY_CLK(jclk[2]),
        .JOY_LOAD(jload[2]), .JOY_SELECT(jsel[2]), .joy_raw(raw2), .done(jdone[2]), .busy(jbusy[2])
    );

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // chain model: parallel load while LOAD low, MSB first, shift on JOY_CLK rise
    logic [47:0] words[3][4];
    logic [47:0] sr[3];
    logic [2:0]  midx[3];
    logic        mbusy[3], mload[3], mclk[3];
    initial for (int i = 0; i < 3; i++) begin
        sr[i] = '0; midx[i] = '0; mbusy[i] = 1'b0; mload[i] = 1'b1; mclk[i] = 1'b0;
        for (int p = 0; p < 4; p++) words[i][p] = '0;
    end
    assign jdata = {sr[2][47], sr[1][15], sr[0][15]};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (jbusy[i] && !mbusy[i]) midx[i] <= '0;
            else if (jload[i] && !mload[i]) midx[i] <= midx[i] + 3'd1;
            if (!jload[i]) sr[i] <= words[i][midx[i][1:0]];
            else if (jclk[i] && !mclk[i]) sr[i] <= sr[i] << 1;
            mbusy[i] <= jbusy[i];
            mload[i] <= jload[i];
            mclk[i]  <= jclk[i];
        end
    end

    // protocol checker
    int   lenv[3] = '{16, 16, 48};
    int   lowcnt[3], rises[3];
    logic active[3], selv[3], pclk[3], pload[3];
    initial for (int i = 0; i < 3; i++) begin
        lowcnt[i] = 0; rises[i] = 0; active[i] = 1'b0; selv[i] = 1'b1; pclk[i] = 1'b0; pload[i] = 1'b1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                lowcnt[i] = 0; rises[i] = 0; active[i] = 1'b0;
            end else begin
                if (!jload[i]) chk("load_vs_clk", {191'd0, jclk[i]}, 192'd0);
                if (!jload[i] && pload[i]) begin
                    if (active[i]) chk("rises_per_phase", rises[i], lenv[i]);
                    active[i] = 1'b1; rises[i] = 0; selv[i] = jsel[i];
                end
                if (!jload[i]) lowcnt[i]++;
                else if (!pload[i]) begin
                    chk("load_width", lowcnt[i], 4);
                    lowcnt[i] = 0;
                end
                if (active[i]) begin
                    if (jclk[i] && !pclk[i]) rises[i]++;
                    if (rises[i] < lenv[i] || jclk[i]) chk("sel_stable", {191'd0, jsel[i]}, {191'd0, selv[i]});
                end
                if (jdone[i]) begin
                    chk("rises_last_phase", rises[i], lenv[i]);
                    active[i] = 1'b0;
                end
            end
            pclk[i] = jclk[i];
            pload[i] = jload[i];
        end
    end

    // scoreboard and busy-length recorder
    logic [191:0] q0[$], q1[$], q2[$];
    int bcnt[3] = '{0, 0, 0};
    int blen[3] = '{0, 0, 0};

    always @(negedge clk) begin
        if (rst_n) begin
            if (jdone[0]) begin
                if (q0.size() == 0) chk("done0_unexpected", 1, 0);
                else chk("raw0", raw0, q0.pop_front());
            end
            if (jdone[1]) begin
                if (q1.size() == 0) chk("done1_unexpected", 1, 0);
                else chk("raw1", raw1, q1.pop_front());
            end
            if (jdone[2]) begin
                if (q2.size() == 0) chk("done2_unexpected", 1, 0);
                else chk("raw2", raw2, q2.pop_front());
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) bcnt[i] = 0;
            else if (jbusy[i]) bcnt[i]++;
            else if (bcnt[i] != 0) begin
                blen[i] = bcnt[i];
                bcnt[i] = 0;
            end
        end
    end

    task automatic wait_busy(input int i, input logic v, input int lim);
        int n = 0;
        while (jbusy[i] !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy", {191'd0, jbusy[i]}, {191'd0, v});
    endtask

    task automatic wait_all_idle();
        for (int i = 0; i < 3; i++) wait_busy(i, 1'b0, 2500);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_jclk0();
        int n = 0;
        while (!jclk[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("jclk_seen", {191'd0, jclk[0]}, 192'd1);
    endtask

    task automatic chk_reset();
        for (int i = 0; i < 3; i++) begin
            chk("rst_jclk", {191'd0, jclk[i]}, 192'd0);
            chk("rst_jload", {191'd0, jload[i]}, 192'd1);
            chk("rst_jsel", {191'd0, jsel[i]}, 192'd1);
            chk("rst_done", {191'd0, jdone[i]}, 192'd0);
            chk("rst_busy", {191'd0, jbusy[i]}, 192'd0);
        end
        chk("rst_raw0", raw0, 0);
        chk("rst_raw1", raw1, 0);
        chk("rst_raw2", raw2, 0);
    endtask

    typedef struct {
        logic [15:0] w0, w1;
        logic [31:0] e_al, e_ah;
    } vec_t;
    vec_t vecs[4];
    logic [191:0] exp2;

    task automatic load_vec(input int k);
        words[0][0] = {32'd0, vecs[k].w0};
        words[0][1] = {32'd0, vecs[k].w1};
        words[1][0] = {32'd0, vecs[k].w0};
        words[1][1] = {32'd0, vecs[k].w1};
    endtask

    task automatic push_vec(input int k);
        q0.push_back({160'd0, vecs[k].e_al});
        q1.push_back({160'd0, vecs[k].e_ah});
    endtask

    initial begin
        int n;
        int lc;
        vecs[0] = '{w0: 16'hA5C3, w1: 16'h0FF0, e_al: 32'hF00F_5A3C, e_ah: 32'h0FF0_A5C3};
        vecs[1] = '{w0: 16'h0000, w1: 16'hFFFF, e_al: 32'h0000_FFFF, e_ah: 32'hFFFF_0000};
        vecs[2] = '{w0: 16'h8001, w1: 16'h7FFE, e_al: 32'h8001_7FFE, e_ah: 32'h7FFE_8001};
        vecs[3] = '{w0: 16'h1234, w1: 16'hABCD, e_al: 32'h5432_EDCB, e_ah: 32'hABCD_1234};
        exp2 = '0;
        for (int p = 0; p < 4; p++) begin
            words[2][p] = 48'h1 << (47 - p);
            exp2[p*48 + 47 - p] = 1'b1;
        end

        repeat (3) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            load_vec(k);
            push_vec(k);
            q2.push_back(exp2);
            en = 1'b1;
            wait_busy(0, 1'b1, 40);
            en = 1'b0;
            wait_all_idle();
            if (k == 0) begin
                chk("frame_clk_u0", blen[0], 344);
                chk("frame_clk_u2", blen[2], 1648);
            end
        end

        // en held high: two back-to-back frames on u0/u1, one IDLE tick between them
        push_vec(3);
        push_vec(3);
        q2.push_back(exp2);
        en = 1'b1;
        wait_busy(0, 1'b1, 40);
        wait_busy(0, 1'b0, 400);
        n = 0;
        while (!jbusy[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_gap_clk", n, 4);
        en = 1'b0;
        wait_all_idle();

        // en dropped during phase 0 SHIFT: frame still completes, nothing afterwards
        load_vec(0);
        push_vec(0);
        q2.push_back(exp2);
        en = 1'b1;
        wait_busy(0, 1'b1, 40);
        wait_jclk0();
        en = 1'b0;
        wait_all_idle();
        lc = 0;
        repeat (600) begin
            @(negedge clk);
            if (jload != 3'b111 || jbusy != 3'b000) lc++;
        end
        chk("no_activity_after_stop", lc, 0);

        // asynchronous reset during SHIFT, then a clean frame
        en = 1'b1;
        wait_busy(0, 1'b1, 40);
        wait_jclk0();
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset();
        repeat (3) @(negedge clk);
        load_vec(2);
        push_vec(2);
        q2.push_back(exp2);
        rst_n = 1'b1;
        wait_busy(0, 1'b1, 40);
        en = 1'b0;
        wait_all_idle();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
